// File: rtl/bnn_conv_sequencer.sv
// Sequencer for a binary conv layer: steps through every (filter, row, col) output position,
// hands each one to a single-neuron datapath, and streams the returned bits out.
// Defining BNN_SEQ_ABORT_EN adds an abort input that drops the pass in progress.
module bnn_conv_sequencer #(
  parameter int IMG_IN_SIZE   = 28,
  parameter int KERNEL_SIZE   = 3,
  parameter int BNN_OUT_CHANL = 16,
  parameter int IMG_OUT_SIZE  = IMG_IN_SIZE - KERNEL_SIZE + 1,
  localparam int POS_W   = (IMG_OUT_SIZE > 1) ? $clog2(IMG_OUT_SIZE) : 1,
  localparam int OC_W    = (BNN_OUT_CHANL > 1) ? $clog2(BNN_OUT_CHANL) : 1,
  localparam int NUM_OUT = BNN_OUT_CHANL * IMG_OUT_SIZE * IMG_OUT_SIZE,
  localparam int IDX_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef BNN_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [POS_W-1:0] req_row,
  output logic [POS_W-1:0] req_col,
  output logic [OC_W-1:0]  req_oc,
  input  logic             rsp_valid,
  input  logic             rsp_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic [IDX_W-1:0] out_index
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} state_t;

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(IMG_OUT_SIZE - 1);
  localparam logic [OC_W-1:0]  OC_LAST  = OC_W'(BNN_OUT_CHANL - 1);

  state_t           r_state;
  logic [POS_W-1:0] r_row;
  logic [POS_W-1:0] r_col;
  logic [OC_W-1:0]  r_oc;
  logic [IDX_W-1:0] r_idx;
  logic             r_out_bit;
  logic             r_done;

  state_t           w_state_nxt;
  logic             w_abort;
  logic             w_out_fire;
  logic             w_last;

`ifdef BNN_SEQ_ABORT_EN
  assign w_abort = abort && (r_state != IDLE);
`else
  assign w_abort = 1'b0;
`endif

  assign w_out_fire = (r_state == EMIT) && out_ready;
  assign w_last     = (r_oc == OC_LAST) && (r_row == POS_LAST) && (r_col == POS_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start)     w_state_nxt = ISSUE;
      ISSUE:   if (req_ready) w_state_nxt = WAIT;
      WAIT:    if (rsp_valid) w_state_nxt = EMIT;
      EMIT:    if (out_ready) w_state_nxt = w_last ? IDLE : ISSUE;
      default:                w_state_nxt = IDLE;
    endcase
    if (w_abort) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_row     <= '0;
      r_col     <= '0;
      r_oc      <= '0;
      r_idx     <= '0;
      r_out_bit <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_out_fire && w_last && !w_abort;
      if (w_abort || ((r_state == IDLE) && start)) begin
        r_row <= '0;
        r_col <= '0;
        r_oc  <= '0;
        r_idx <= '0;
      end else if (w_out_fire) begin
        // col fastest, then row, then filter; everything wraps to 0 after the last element
        r_idx <= w_last ? '0 : r_idx + 1'b1;
        if (r_col == POS_LAST) begin
          r_col <= '0;
          if (r_row == POS_LAST) begin
            r_row <= '0;
            r_oc  <= (r_oc == OC_LAST) ? '0 : r_oc + 1'b1;
          end else begin
            r_row <= r_row + 1'b1;
          end
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      if ((r_state == WAIT) && rsp_valid && !w_abort) r_out_bit <= rsp_bit;
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign req_valid = (r_state == ISSUE);
  assign out_valid = (r_state == EMIT);
  assign req_row   = r_row;
  assign req_col   = r_col;
  assign req_oc    = r_oc;
  assign out_bit   = r_out_bit;
  assign out_index = r_idx;

endmodule

// File: tb/tb_bnn_conv_sequencer.sv
// Bench for bnn_conv_sequencer on a 4x4 input, 3x3 kernel, 2 filters (8 outputs):
// a cycle table for the nominal pass, directed stall/reset sequences, and randomized passes.
module tb_bnn_conv_sequencer;
  localparam int IMG_IN_SIZE   = 4;
  localparam int KERNEL_SIZE   = 3;
  localparam int BNN_OUT_CHANL = 2;
  localparam int S             = IMG_IN_SIZE - KERNEL_SIZE + 1;
  localparam int NUM_OUT       = BNN_OUT_CHANL * S * S;

  logic       clk = 1'b0;
  logic       rst, start, req_ready, rsp_valid, rsp_bit, out_ready;
  logic       busy, done, req_valid, out_valid, out_bit;
  logic [0:0] req_row, req_col, req_oc;
  logic [2:0] out_index;
`ifdef BNN_SEQ_ABORT_EN
  logic       abort = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bnn_conv_sequencer #(
    .IMG_IN_SIZE  (IMG_IN_SIZE),
    .KERNEL_SIZE  (KERNEL_SIZE),
    .BNN_OUT_CHANL(BNN_OUT_CHANL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
`ifdef BNN_SEQ_ABORT_EN
    .abort    (abort),
`endif
    .busy     (busy),
    .done     (done),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_row  (req_row),
    .req_col  (req_col),
    .req_oc   (req_oc),
    .rsp_valid(rsp_valid),
    .rsp_bit  (rsp_bit),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_bit  (out_bit),
    .out_index(out_index)
  );

  typedef struct {
    logic start, req_ready, rsp_valid, rsp_bit, out_ready;
    logic busy, done, req_valid, out_valid, out_bit;
    int   idx;
  } vec_t;

  vec_t tbl[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_coords(input string nm, input int idx);
    chk({nm, " req_oc"},  32'(req_oc),  32'(idx / (S * S)));
    chk({nm, " req_row"}, 32'(req_row), 32'((idx / S) % S));
    chk({nm, " req_col"}, 32'(req_col), 32'(idx % S));
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, " busy"},      32'(busy),      0);
    chk({nm, " done"},      32'(done),      0);
    chk({nm, " req_valid"}, 32'(req_valid), 0);
    chk({nm, " out_valid"}, 32'(out_valid), 0);
  endtask

  task automatic clear_inputs();
    start = 0; req_ready = 0; rsp_valid = 0; rsp_bit = 0; out_ready = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    repeat (2) tick();
    rst = 0;
    chk_idle("reset");
    chk("reset out_bit",   32'(out_bit),   0);
    chk("reset out_index", 32'(out_index), 0);
    chk_coords("reset", 0);
  endtask

  // DUT sits in ISSUE for element idx on entry and in ISSUE/done state on exit.
  task automatic elem(input int idx, input bit b);
    chk_coords($sformatf("elem%0d", idx), idx);
    req_ready = 1; tick(); req_ready = 0;
    chk($sformatf("elem%0d wait req_valid", idx), 32'(req_valid), 0);
    rsp_valid = 1; rsp_bit = b; tick(); rsp_valid = 0;
    chk($sformatf("elem%0d out_valid", idx), 32'(out_valid), 1);
    chk($sformatf("elem%0d out_index", idx), 32'(out_index), 32'(idx));
    chk($sformatf("elem%0d out_bit", idx),   32'(out_bit),   32'(b));
    out_ready = 1; tick(); out_ready = 0;
  endtask

  task automatic run_pass(input int pass);
    bit bits[NUM_OUT];
    int idx = 0;
    int dly = 0;
    bit waiting = 0, exp_req = 1, exp_emit = 0, exp_done = 0, fin = 0;
    for (int i = 0; i < NUM_OUT; i++) bits[i] = 1'($urandom_range(0, 1));
    start = 1; tick(); start = 0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (exp_done) begin
        chk($sformatf("rnd%0d done", pass),      32'(done),      1);
        chk($sformatf("rnd%0d done busy", pass), 32'(busy),      0);
        chk($sformatf("rnd%0d done ov", pass),   32'(out_valid), 0);
        fin = 1;
      end else begin
        chk($sformatf("rnd%0d done early", pass), 32'(done), 0);
        chk($sformatf("rnd%0d busy", pass),       32'(busy), 1);
        if (exp_req)  chk($sformatf("rnd%0d req_valid", pass), 32'(req_valid), 1);
        if (exp_emit) chk($sformatf("rnd%0d out_valid", pass), 32'(out_valid), 1);
        if (req_valid) begin
          chk($sformatf("rnd%0d outstanding", pass), 32'(waiting | out_valid), 0);
          chk_coords($sformatf("rnd%0d i%0d", pass, idx), idx);
        end
        if (out_valid) begin
          chk($sformatf("rnd%0d out_index", pass), 32'(out_index), 32'(idx));
          chk($sformatf("rnd%0d out_bit", pass),   32'(out_bit),   32'(bits[idx]));
        end
      end
      exp_req = 0;
      exp_emit = 0;
      if (!fin) begin
        if (waiting) begin
          if (dly == 0) begin
            rsp_valid = 1; rsp_bit = bits[idx]; waiting = 0; exp_emit = 1;
          end else begin
            rsp_valid = 0; dly--;
          end
        end else begin
          rsp_valid = ($urandom_range(0, 3) == 0);
          rsp_bit   = !bits[(idx < NUM_OUT) ? idx : 0];
        end
        req_ready = ($urandom_range(0, 2) != 0);
        if (req_valid && req_ready) begin
          waiting = 1;
          dly = $urandom_range(0, 3);
        end
        out_ready = ($urandom_range(0, 2) != 0);
        if (out_valid && out_ready) begin
          idx++;
          if (idx == NUM_OUT) exp_done = 1;
          else exp_req = 1;
        end
        start = ($urandom_range(0, 7) == 0);
        tick();
      end
    end
    if (!fin) chk($sformatf("rnd%0d pass timeout", pass), 0, 1);
    clear_inputs();
  endtask

  initial begin
    vec_t v;
    rst = 1;
    clear_inputs();

    // nominal pass, one row per clock: inputs before the edge, outputs after it
    v = '{default: 0}; v.start = 1; v.busy = 1; v.req_valid = 1; v.idx = 0; tbl.push_back(v);
    for (int e = 0; e < NUM_OUT; e++) begin
      v = '{default: 0}; v.req_ready = 1; v.busy = 1; v.idx = e; tbl.push_back(v);
      v = '{default: 0}; v.rsp_valid = 1; v.rsp_bit = 1'(e % 2); v.busy = 1;
      v.out_valid = 1; v.out_bit = 1'(e % 2); v.idx = e; tbl.push_back(v);
      v = '{default: 0}; v.out_ready = 1;
      if (e < NUM_OUT - 1) begin
        v.busy = 1; v.req_valid = 1; v.idx = e + 1;
      end else begin
        v.done = 1; v.idx = -1;
      end
      tbl.push_back(v);
    end
    v = '{default: 0}; v.start = 1; v.busy = 1; v.req_valid = 1; v.idx = 0; tbl.push_back(v);

    do_reset();

    foreach (tbl[i]) begin
      start = tbl[i].start; req_ready = tbl[i].req_ready; rsp_valid = tbl[i].rsp_valid;
      rsp_bit = tbl[i].rsp_bit; out_ready = tbl[i].out_ready;
      tick();
      chk($sformatf("tbl%0d busy", i),      32'(busy),      32'(tbl[i].busy));
      chk($sformatf("tbl%0d done", i),      32'(done),      32'(tbl[i].done));
      chk($sformatf("tbl%0d req_valid", i), 32'(req_valid), 32'(tbl[i].req_valid));
      chk($sformatf("tbl%0d out_valid", i), 32'(out_valid), 32'(tbl[i].out_valid));
      if (tbl[i].idx >= 0) begin
        chk_coords($sformatf("tbl%0d", i), tbl[i].idx);
        if (tbl[i].out_valid) begin
          chk($sformatf("tbl%0d out_index", i), 32'(out_index), 32'(tbl[i].idx));
          chk($sformatf("tbl%0d out_bit", i),   32'(out_bit),   32'(tbl[i].out_bit));
        end
      end
    end

    // stalls and a mid-pass start
    do_reset();
    start = 1; tick(); start = 0;
    elem(0, 0); elem(1, 1);
    start = 1; tick(); start = 0;
    chk("restart ignored req_valid", 32'(req_valid), 1);
    chk_coords("restart ignored", 2);
    elem(2, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("req stall%0d req_valid", k), 32'(req_valid), 1);
      chk($sformatf("req stall%0d out_valid", k), 32'(out_valid), 0);
      chk_coords($sformatf("req stall%0d", k), 3);
    end
    elem(3, 1); elem(4, 0);
    req_ready = 1; tick(); req_ready = 0;
    rsp_valid = 1; rsp_bit = 1; tick();
    for (int k = 0; k < 4; k++) begin
      rsp_bit = 0;
      chk($sformatf("out stall%0d out_valid", k), 32'(out_valid), 1);
      chk($sformatf("out stall%0d out_index", k), 32'(out_index), 5);
      chk($sformatf("out stall%0d out_bit", k),   32'(out_bit),   1);
      tick();
    end
    rsp_valid = 0;
    chk("out stall end out_index", 32'(out_index), 5);
    chk("out stall end out_bit",   32'(out_bit),   1);
    out_ready = 1; tick(); out_ready = 0;
    chk("after stall req_valid", 32'(req_valid), 1);
    elem(6, 0); elem(7, 1);
    chk("stall pass done",      32'(done),      1);
    chk("stall pass busy",      32'(busy),      0);
    chk("stall pass out_valid", 32'(out_valid), 0);
    tick();
    chk("stall pass done pulse", 32'(done), 0);

    // reset in the middle of a pass, then a late datapath response
    start = 1; tick(); start = 0;
    for (int i = 0; i < 4; i++) elem(i, 1'(i % 2));
    req_ready = 1; tick(); req_ready = 0;
    rst = 1; tick(); rst = 0;
    chk_idle("midreset");
    chk("midreset out_index", 32'(out_index), 0);
    rsp_valid = 1; rsp_bit = 1; tick(); rsp_valid = 0;
    chk_idle("late rsp");
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("midreset quiet%0d done", k), 32'(done), 0);
    end
    start = 1; tick(); start = 0;
    chk("post reset restart req_valid", 32'(req_valid), 1);
    chk_coords("post reset restart", 0);

`ifdef BNN_SEQ_ABORT_EN
    do_reset();
    start = 1; tick(); start = 0;
    for (int i = 0; i < 4; i++) elem(i, 1'(i % 2));
    abort = 1; req_ready = 1; tick(); abort = 0; req_ready = 0;
    chk_idle("abort");
    tick();
    chk("abort no done", 32'(done), 0);
    start = 1; tick(); start = 0;
    chk_coords("post abort restart", 0);
`endif

    // randomized passes; back-to-back ones start in the previous pass's done cycle
    do_reset();
    for (int p = 0; p < 20; p++) begin
      run_pass(p);
      if ($urandom_range(0, 1) == 1) begin
        tick();
        chk($sformatf("gap%0d done", p), 32'(done), 0);
        chk($sformatf("gap%0d busy", p), 32'(busy), 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
